// File: rtl/branch_predictor_if.sv
// Fetch/EX-side bus of the branch predictor: lookup, training update,
// redirect and statistics.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     branch_cnt;
    logic [31:0]     mispredict_cnt;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational lookup for IF,
// registered training from EX, combinational mispredict/redirect and statistics.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       ctr;
    } bte_t;

    localparam bte_t BTE_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};

    bte_t btb [ENTRIES];

    logic [IDX_W-1:0] lk_idx, ex_idx;
    logic [TAG_W-1:0] lk_tag, ex_tag;
    bte_t             lk_e, ex_e;
    logic             lk_hit, ex_hit;
    logic [31:0]      branch_cnt_q, mispredict_cnt_q;
    logic             misp;

    // Byte offset bits never participate in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};

    assign lk_idx = bp.if_pc[IDX_W+1:2];
    assign lk_tag = bp.if_pc[XLEN-1:IDX_W+2];
    assign ex_idx = bp.ex_pc[IDX_W+1:2];
    assign ex_tag = bp.ex_pc[XLEN-1:IDX_W+2];

    assign lk_e   = btb[lk_idx];
    assign ex_e   = btb[ex_idx];
    assign lk_hit = lk_e.valid && (lk_e.tag == lk_tag);
    assign ex_hit = ex_e.valid && (ex_e.tag == ex_tag);

    assign bp.pred_taken  = lk_hit && lk_e.ctr[1];
    assign bp.pred_target = bp.pred_taken ? lk_e.target : bp.if_pc + XLEN'(4);

    assign misp = rst_n && bp.ex_valid &&
                  ((bp.ex_taken != bp.ex_pred_taken) ||
                   (bp.ex_taken && (bp.ex_pred_target != bp.ex_target)));
    assign bp.mispredict  = misp;
    assign bp.redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + XLEN'(4);

    // Lookup reads the pre-edge array, so a same-cycle update is not bypassed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) btb[i] <= BTE_RST;
        end else if (bp.ex_valid) begin
            if (ex_hit) begin
                if (bp.ex_taken) begin
                    btb[ex_idx].ctr    <= (ex_e.ctr == 2'b11) ? 2'b11 : ex_e.ctr + 2'b01;
                    btb[ex_idx].target <= bp.ex_target;
                end else begin
                    btb[ex_idx].ctr    <= (ex_e.ctr == 2'b00) ? 2'b00 : ex_e.ctr - 2'b01;
                end
            end else if (bp.ex_taken) begin
                btb[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: bp.ex_target, ctr: 2'b10};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (bp.ex_valid) branch_cnt_q     <= branch_cnt_q + 32'd1;
            if (misp)        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign bp.branch_cnt     = branch_cnt_q;
    assign bp.mispredict_cnt = mispredict_cnt_q;
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor: direct-mapped BTB with per-entry 2-bit saturating counters, so IF can guess the next PC.
- Counterpart to the EX-stage branch resolution logic. Consumes the EX take/not-take decision and target as training updates.
- Emits the mispredict/redirect signal back to fetch.
- Maintains branch and mispredict statistics counters.

Parameters:
- XLEN, 32, PC/target width.
- ENTRIES, 64, BTB entries; power of two, at least 2. IDX_W = log2(ENTRIES).
- TAG_W, XLEN-IDX_W-2, derived; tag width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_pc  in  XLEN  fetch PC for lookup
- pred_taken  out  1  prediction: taken
- pred_target  out  XLEN  predicted next PC
- ex_valid  in  1  resolved conditional branch in EX this cycle
- ex_pc  in  XLEN  PC of resolved branch
- ex_taken  in  1  actual outcome (take_branch from EX)
- ex_target  in  XLEN  computed branch target
- ex_pred_taken  in  1  prediction carried down the pipe with this branch
- ex_pred_target  in  XLEN  predicted target carried down the pipe
- mispredict  out  1  flush/redirect request
- redirect_pc  out  XLEN  correct next PC when mispredict=1
- branch_cnt  out  32  resolved-branch count
- mispredict_cnt  out  32  mispredict count

Behaviour:
- Indexing:
  - idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry state: valid (1b), tag (TAG_W), target (XLEN), ctr (2b).
- Reset (async assert, sync-deasserted externally):
  - all valid=0, ctr=2'b01, tag/target=0.
  - branch_cnt=0, mispredict_cnt=0.
  - mispredict=0, forced while rst_n low.
  - pred_taken=0, pred_target=if_pc+4.
  - Reset mid-update discards the update.
- Lookup is combinational, zero latency:
  - hit = valid[idx] && tag[idx]==tag(if_pc).
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4, modulo 2^XLEN.
- Update is registered at the clk edge when ex_valid=1, using idx/tag of ex_pc:
  - hit, taken: ctr = min(ctr+1, 3); target = ex_target.
  - hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - miss, taken: allocate (overwrite any aliasing entry); valid=1, tag, target=ex_target, ctr=2'b10.
  - miss, not taken: no state change.
- Mispredict is combinational:
  - mispredict = ex_valid && (ex_taken!=ex_pred_taken || (ex_taken && ex_pred_target!=ex_target)).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4; driven every cycle, meaningful only when mispredict=1.
- Statistics:
  - branch_cnt += 1 on each ex_valid cycle.
  - mispredict_cnt += 1 on each mispredict cycle.
  - Both wrap 0xFFFFFFFF -> 0.
- Simultaneous lookup and update to the same idx: lookup returns pre-update state; no bypass. New state is visible the next cycle.
- ex_valid=0: no state change. ex_* values are don't-care.
- No stall input. Lookup is pure read; update ignores IF activity.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104; counters 0.
- Cold miss: ex_valid, ex_pc=0x100, taken, target=0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80. mispredict_cnt=1.
- Counter training: four not-taken updates at 0x100 after allocation -> ctr saturates at 0, pred_taken=0. Five taken updates -> ctr=3. One not-taken -> ctr=2, still predicts taken.
- Alias (ENTRIES=64): allocate 0x100 -> 0x80, then taken 0x200 (same idx) -> 0x40 -> lookup 0x100 misses, lookup 0x200 hits with target 0x40.
- Target mismatch: pred_taken=1, pred_target=0x80, ex_taken=1, ex_target=0x90 -> mispredict=1, redirect_pc=0x90, entry target becomes 0x90. Not-taken mispredict at 0x100 -> redirect_pc=0x104.
- Same-cycle update/lookup at 0x100 during allocation -> that cycle pred_taken=0, next cycle 1. Assert rst_n low mid-sequence -> all entries invalid, counters 0 immediately. Preload branch_cnt to 0xFFFFFFFF, one more branch -> branch_cnt=0.
